// File: rtl/rkey_store_ctrl_pkg.sv
// rkey_store_ctrl_pkg: shared types and sizes for the AES round-key store.
package rkey_store_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, READY} rks_state_t;
  typedef logic [127:0] rkey_t;
  localparam int RK_AW = 4;
endpackage

// File: rtl/rkey_store_ctrl_xram.sv
// xram_16x64: 16x64 storage with synchronous write and combinational read.
module xram_16x64
  import rkey_store_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             wr_i,
  input  logic [RK_AW-1:0] wr_addr_i,
  input  logic [63:0]      wr_data_i,
  input  logic [RK_AW-1:0] rd_addr_i,
  output logic [63:0]      rd_data_o
);
  logic [63:0] mem_q [2**RK_AW];
  always_ff @(posedge clk) if (wr_i) mem_q[wr_addr_i] <= wr_data_i;
  assign rd_data_o = mem_q[rd_addr_i];
endmodule

// File: rtl/rkey_store_ctrl.sv
// rkey_store_ctrl: sequences in-order round-key writes and serves registered reads.
module rkey_store_ctrl
  import rkey_store_ctrl_pkg::*;
#(
  parameter int NUM_RK = 11,
  parameter int AW     = RK_AW,
  parameter int DW     = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          key_start_i,
  input  logic          kx_valid_i,
  input  logic [DW-1:0] kx_data_i,
  output logic          kx_ready_o,
  input  logic          rd_req_i,
  input  logic [AW-1:0] rd_idx_i,
  output logic          rd_stall_o,
  output logic          rd_valid_o,
  output logic [DW-1:0] rd_data_o,
  output logic          rd_err_o,
  output logic          keys_ready_o
);
  localparam logic [AW:0] NRK  = (AW+1)'(NUM_RK);
  localparam logic [AW:0] LAST = (AW+1)'(NUM_RK - 1);
  rks_state_t      state_q;
  logic [AW:0]     wr_cnt_q;
  logic            rd_valid_q, rd_err_q;
  logic [DW-1:0]   rd_data_q;
  logic [DW/2-1:0] ram_hi, ram_lo;
  logic            in_rng, hit, wr_en;
  assign in_rng = {1'b0, rd_idx_i} < NRK;
  // a key is readable only once its write has landed, so same-cycle write+read stalls
  assign hit    = rd_req_i & ({1'b0, rd_idx_i} < wr_cnt_q) & in_rng & ~key_start_i;
  assign wr_en  = kx_valid_i & (state_q == LOAD) & ~key_start_i;
  assign rd_stall_o   = rd_req_i & ~hit & in_rng;
  assign kx_ready_o   = state_q == LOAD;
  assign keys_ready_o = state_q == READY;
  assign rd_valid_o   = rd_valid_q;
  assign rd_data_o    = rd_data_q;
  assign rd_err_o     = rd_err_q;
  xram_16x64 u_ram_hi (
    .clk(clk), .wr_i(wr_en), .wr_addr_i(wr_cnt_q[AW-1:0]), .wr_data_i(kx_data_i[DW-1:DW/2]),
    .rd_addr_i(rd_idx_i), .rd_data_o(ram_hi)
  );
  xram_16x64 u_ram_lo (
    .clk(clk), .wr_i(wr_en), .wr_addr_i(wr_cnt_q[AW-1:0]), .wr_data_i(kx_data_i[DW/2-1:0]),
    .rd_addr_i(rd_idx_i), .rd_data_o(ram_lo)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_cnt_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= hit;
      rd_err_q   <= rd_req_i & ~in_rng;
      if (hit) rd_data_q <= {ram_hi, ram_lo};
      if (key_start_i) begin
        state_q  <= LOAD;
        wr_cnt_q <= '0;
      end else if (wr_en) begin
        wr_cnt_q <= wr_cnt_q + (AW+1)'(1);
        if (wr_cnt_q == LAST) state_q <= READY;
      end
    end
  end
endmodule

// File: tb/tb_rkey_store_ctrl.sv
// tb_rkey_store_ctrl: directed and random stimulus against a schedule-level model.
module tb_rkey_store_ctrl;
  localparam int NUM_RK = 11;
  logic         clk = 0, rst = 1;
  logic         key_start = 0, kx_valid = 0, rd_req = 0;
  logic [127:0] kx_data = '0;
  logic [3:0]   rd_idx = '0;
  logic         kx_ready, rd_stall, rd_valid, rd_err, keys_ready;
  logic [127:0] rd_data;
  int total = 0, bad = 0;
  logic [127:0] m_mem [16];
  int           m_written;
  bit           m_loading, m_complete;
  logic [127:0] e_data;
  bit           e_valid, e_err;

  rkey_store_ctrl #(.NUM_RK(NUM_RK)) dut (
    .clk(clk), .rst(rst), .key_start_i(key_start), .kx_valid_i(kx_valid), .kx_data_i(kx_data),
    .kx_ready_o(kx_ready), .rd_req_i(rd_req), .rd_idx_i(rd_idx), .rd_stall_o(rd_stall),
    .rd_valid_o(rd_valid), .rd_data_o(rd_data), .rd_err_o(rd_err), .keys_ready_o(keys_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_data", rd_data, e_data);
    chk("rd_err", rd_err, e_err);
    chk("keys_ready", keys_ready, m_complete);
    chk("kx_ready", kx_ready, m_loading);
  endtask

  task automatic do_reset();
    rst = 1; key_start = 0; kx_valid = 0; rd_req = 0;
    @(posedge clk); #1;
    rst = 0;
    m_written = 0; m_loading = 0; m_complete = 0;
    e_data = '0; e_valid = 0; e_err = 0;
    chk_outputs();
  endtask

  task automatic step(input bit ks, input bit kv, input logic [127:0] kd, input bit rq, input int ri);
    bit served, inr;
    key_start = ks; kx_valid = kv; kx_data = kd; rd_req = rq; rd_idx = 4'(ri);
    #2;
    inr    = ri < NUM_RK;
    served = rq && inr && ri < m_written && !ks;
    chk("rd_stall", rd_stall, rq && inr && !served);
    chk("kx_ready_pre", kx_ready, m_loading);
    e_valid = served;
    e_err   = rq && !inr;
    if (served) e_data = m_mem[ri];
    if (ks) begin
      m_written = 0; m_loading = 1; m_complete = 0;
    end else if (m_loading && kv) begin
      m_mem[m_written] = kd;
      m_written++;
      if (m_written == NUM_RK) begin m_loading = 0; m_complete = 1; end
    end
    @(posedge clk); #1;
    chk_outputs();
    key_start = 0; kx_valid = 0; rd_req = 0;
  endtask

  function automatic logic [127:0] pat(input int i);
    logic [3:0] n = 4'(i);
    return {32{n}};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    @(posedge clk); #1;
    do_reset();
    step(0, 0, '0, 1, 0);
    step(1, 0, '0, 0, 0);
    for (int i = 0; i < NUM_RK; i++) step(0, 1, pat(i), 0, 0);
    for (int i = 0; i < NUM_RK; i++) step(0, 0, '0, 1, i);
    step(0, 0, '0, 1, 11);
    step(0, 0, '0, 1, 15);
    step(0, 0, '0, 1, 4);
    step(1, 1, rnd128(), 1, 2);
    step(0, 1, rnd128(), 0, 0);
    step(0, 1, rnd128(), 0, 0);
    step(0, 1, rnd128(), 0, 0);
    step(0, 0, '0, 1, 2);
    step(0, 0, '0, 1, 3);
    step(0, 1, rnd128(), 1, 3);
    step(0, 0, '0, 1, 3);
    step(0, 1, rnd128(), 1, 4);
    step(0, 1, rnd128(), 0, 0);
    do_reset();
    step(0, 0, '0, 1, 0);
    step(0, 1, rnd128(), 1, 0);
    step(1, 0, '0, 1, 0);
    step(0, 1, rnd128(), 1, 0);
    step(0, 0, '0, 1, 0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) do_reset();
      else step($urandom_range(24) == 0, $urandom_range(3) != 0, rnd128(),
                $urandom_range(1) == 1, int'($urandom_range(12)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
